// File: rtl/bcd_scan_counter.sv
// Multi-digit BCD up/down counter with a time-multiplexed, active-low digit scanner.
// Optional leading-zero blanking is enabled by defining BCD_SCAN_BLANK_LZ_EN.
module bcd_scan_counter #(
  parameter int DIGITS   = 4,
  parameter int TICK_DIV = 100000,
  parameter int SCAN_DIV = 1000
) (
  input  logic              iClk,
  input  logic              iRst,
  input  logic              iEn,
  input  logic              iUp,
  input  logic              iClr,
  output logic [3:0]        oData,
  output logic [DIGITS-1:0] oSel,
  output logic              oCarry
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [TW-1:0] tickCnt;
  logic [SW-1:0] scanCnt;
  logic [IW-1:0] scanIdx;
  logic [3:0]    digits     [DIGITS];
  logic [3:0]    nextDigits [DIGITS];
  logic          tick;
  logic          scanAdv;
  logic          step;
  logic          ripple;
  logic          wrap;
  logic          blank;
  logic          zeroAbove;

  assign tick    = (tickCnt == TW'(TICK_DIV - 1));
  assign scanAdv = (scanCnt == SW'(SCAN_DIV - 1));
  assign step    = tick & iEn & ~iClr;

  always_ff @(posedge iClk) begin
    if (iRst || tick) begin
      tickCnt <= '0;
    end else begin
      tickCnt <= tickCnt + TW'(1);
    end
  end

  // Ripple carry/borrow through the digits; a ripple that survives the top digit is a wrap.
  always_comb begin
    ripple = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      nextDigits[i] = digits[i];
      if (ripple) begin
        if (iUp) begin
          if (digits[i] == 4'd9) begin
            nextDigits[i] = 4'd0;
          end else begin
            nextDigits[i] = digits[i] + 4'd1;
            ripple        = 1'b0;
          end
        end else begin
          if (digits[i] == 4'd0) begin
            nextDigits[i] = 4'd9;
          end else begin
            nextDigits[i] = digits[i] - 4'd1;
            ripple        = 1'b0;
          end
        end
      end
    end
    wrap = ripple;
  end

  always_ff @(posedge iClk) begin
    if (iRst || iClr) begin
      for (int i = 0; i < DIGITS; i++) begin
        digits[i] <= 4'd0;
      end
    end else if (step) begin
      digits <= nextDigits;
    end
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      oCarry <= 1'b0;
    end else begin
      oCarry <= step & wrap;
    end
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      scanCnt <= '0;
      scanIdx <= '0;
    end else if (scanAdv) begin
      scanCnt <= '0;
      scanIdx <= (scanIdx == IW'(DIGITS - 1)) ? '0 : scanIdx + IW'(1);
    end else begin
      scanCnt <= scanCnt + SW'(1);
    end
  end

`ifdef BCD_SCAN_BLANK_LZ_EN
  // Walk from the top digit down so zeroAbove covers the current slot and everything above it.
  always_comb begin
    zeroAbove = 1'b1;
    blank     = 1'b0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zeroAbove = zeroAbove & (digits[i] == 4'd0);
      if ((i != 0) && (IW'(i) == scanIdx)) begin
        blank = zeroAbove;
      end
    end
  end
`else
  always_comb begin
    zeroAbove = 1'b0;
    blank     = zeroAbove;
  end
`endif

  always_ff @(posedge iClk) begin
    if (iRst || blank) begin
      oSel  <= '1;
      oData <= 4'h0;
    end else begin
      oSel  <= ~(DIGITS'(1) << scanIdx);
      oData <= digits[scanIdx];
    end
  end

endmodule
